vga_draw_arbiter: RTL and testbench
===================================

# vga_draw_arbiter

Job-level arbiter and sequencer that shares the single VGA adapter pixel-write port between several drawing engines (fillscreen, circle, and similar start/done engines). Each engine's client raises a request. The arbiter grants one engine at a time, drives that engine's `start`, steers the engine's pixel stream onto the adapter port, and holds the grant until the engine reports `done`. It sits between the top-level task wrapper and the `vga_adapter`, replacing direct engine-to-adapter wiring.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesting engines (2..8).

Ports (clock and reset first):
- `clk`, in, 1: system clock (CLOCK_50 domain); the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req`, in, NUM_REQ: per-client job request, level.
- `gnt`, out, NUM_REQ: one-hot grant; all zero when idle.
- `eng_start`, out, NUM_REQ: per-engine start, level; high only for the granted engine while its job runs.
- `eng_done`, in, NUM_REQ: per-engine done; held high until the engine's start drops.
- `eng_x`, in, NUM_REQ*8: packed engine x; engine i occupies [8i+7:8i].
- `eng_y`, in, NUM_REQ*7: packed engine y.
- `eng_colour`, in, NUM_REQ*3: packed engine colour.
- `eng_plot`, in, NUM_REQ: per-engine plot strobe.
- `vga_x`, out, 8: pixel x to the adapter.
- `vga_y`, out, 7: pixel y to the adapter.
- `vga_colour`, out, 3: pixel colour to the adapter.
- `vga_plot`, out, 1: pixel write strobe to the adapter.
- `busy`, out, 1: high in GRANT, RUN or RELEASE.
- `job_done`, out, 1: one-cycle pulse when a granted job completes.

## Operation
- State machine:
  - IDLE: evaluate `req`. If any bit is set, register the winner index `w` and go to RUN. In that same edge, set `gnt[w]=1` and `eng_start[w]=1`.
  - RUN: hold the grant and start. If `eng_done[w]` is sampled high, go to RELEASE. In that edge, clear `gnt` and `eng_start`, and pulse `job_done`.
  - RELEASE: one cycle with start low so the engine clears its done. Then go to IDLE.
- GRANT is not a separate state. `busy` equals (state != IDLE).
- Pixel mux:
  - In RUN, `vga_x`, `vga_y` and `vga_colour` equal engine w's slices, and `vga_plot = eng_plot[w]`. This path is combinational from the registered `w`.
  - Outside RUN: `vga_plot = 0`, and x, y and colour are 0.
  - Plot strobes from non-granted engines are ignored.
- A request dropped during RUN is ignored; the job runs to `done`. No pre-emption.
- A request still high after RELEASE is re-arbitrated in IDLE like any other request.
- `eng_done` from a non-granted engine, or in IDLE/RELEASE, is ignored.
- Coordinates pass through unmodified. Range checking is the adapter's responsibility.

## Timing
- Reset, synchronous, at any time including mid-job: on the next edge, state=IDLE, `gnt=0`, `eng_start=0`, `job_done=0`, `busy=0`, `vga_plot=0`, `vga_x/y/colour=0`, round-robin pointer=0. An engine interrupted mid-job sees start drop and must restart from its own reset.
- Grant latency: `req` sampled high in IDLE at edge t gives `gnt`/`eng_start` high after edge t, i.e. in cycle t+1.
- Pixel latency: zero cycles (combinational) from the engine's plot to `vga_plot` during RUN.
- Completion: `eng_done[w]` sampled high at edge d gives start low and a `job_done` pulse in cycle d+1, then RELEASE. The earliest next grant is in cycle d+3.
- Minimum job overhead: 3 cycles (IDLE, RUN entry, RELEASE) beyond the engine's own runtime.
- Simultaneous requests are resolved by the priority rule below. `eng_done` in the same cycle as a new `req` completes the current job first.

## Configuration
- `VGA_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Pointer `p` (reset 0). The search starts at index p and wraps modulo NUM_REQ.
  - After a job by w completes, p = (w+1) mod NUM_REQ.
- Not defined: fixed priority, where the lowest index wins. The pointer logic is compiled out.

## Test plan
- Reset then single request: `req=3'b010` → `gnt=010` and `eng_start[1]=1` one cycle later. Engine 1 plots at (159,119,colour 5) → `vga_x=159`, `vga_y=119`, `vga_colour=5`, `vga_plot=1` the same cycle. `eng_done[1]` → `job_done` pulse, then `gnt=0`.
- Contention with RR enabled: `req=3'b111` held for three jobs → grants issued in order 0, 1, 2, then 0. With the macro undefined → engine 0 is regranted each time.
- Isolation: while engine 0 is granted, drive `eng_plot[2]=1` with x=7 → `vga_plot` follows engine 0 only, and x=7 never appears.
- Request dropped mid-job: deassert `req[0]` during RUN → `gnt[0]` stays high until `eng_done[0]`. There are no extra grants afterwards.
- Reset mid-job: assert `rst_n=0` during RUN → the next cycle has all outputs 0 and state IDLE. After release, `req=3'b100` → grant to engine 2 (pointer reset to 0).

Source files
------------

// File: rtl/vga_draw_arbiter.sv
// Job-level arbiter sharing the VGA adapter pixel port among start/done drawing engines.
// Define VGA_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module vga_draw_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   eng_start,
  input  logic [NUM_REQ-1:0]   eng_done,
  input  logic [NUM_REQ*8-1:0] eng_x,
  input  logic [NUM_REQ*7-1:0] eng_y,
  input  logic [NUM_REQ*3-1:0] eng_colour,
  input  logic [NUM_REQ-1:0]   eng_plot,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 job_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] win_reg, win_next;
  logic [IDX_W-1:0] pick;
  logic             job_end;

  logic [7:0] x_arr      [NUM_REQ];
  logic [6:0] y_arr      [NUM_REQ];
  logic [2:0] colour_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign x_arr[gi]      = eng_x[8*gi +: 8];
      assign y_arr[gi]      = eng_y[7*gi +: 7];
      assign colour_arr[gi] = eng_colour[3*gi +: 3];
    end
  endgenerate

  assign job_end = (state_reg == RUN) && eng_done[win_reg];

`ifdef VGA_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg, ptr_next;

  // Search starts at the pointer and wraps modulo NUM_REQ.
  always_comb begin
    logic             found;
    logic [IDX_W:0]   idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_reg} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) begin
        idx = idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (job_end) begin
      ptr_next = (win_reg == IDX_W'(NUM_REQ-1)) ? '0 : win_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req[k]) begin
        pick = IDX_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      win_reg   <= '0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = RUN;
          win_next   = pick;
        end
      end
      RUN: begin
        if (job_end) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, start and the pixel path are decoded from the registered state and winner.
  always_comb begin
    gnt        = '0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state_reg == RUN) begin
      gnt[win_reg] = 1'b1;
      vga_x        = x_arr[win_reg];
      vga_y        = y_arr[win_reg];
      vga_colour   = colour_arr[win_reg];
      vga_plot     = eng_plot[win_reg];
    end
  end

  assign eng_start = gnt;
  assign busy      = (state_reg != IDLE);
  assign job_done  = (state_reg == RELEASE);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: vector table, hand sequences, randomized model comparison.
module tb_vga_draw_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [N-1:0]   eng_start;
  logic [N-1:0]   eng_done;
  logic [N*8-1:0] eng_x;
  logic [N*7-1:0] eng_y;
  logic [N*3-1:0] eng_colour;
  logic [N-1:0]   eng_plot;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           job_done;

  int checks   = 0;
  int failures = 0;

  // Job-level reference: who owns the port, how many cooldown cycles remain, next search start.
  int m_owner = -1;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_jd    = 1'b0;

  vga_draw_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .eng_start(eng_start),
    .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
    .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    m_jd = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_gap   = 0;
      m_ptr   = 0;
    end else if (m_owner >= 0) begin
      if (eng_done[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
        m_jd    = 1'b1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != '0) begin
`ifdef VGA_ARB_ROUND_ROBIN_EN
      m_owner = pick_winner(req, m_ptr);
`else
      m_owner = pick_winner(req, 0);
`endif
    end
  endtask

  task automatic check_model();
    int eg, ex, ey, ec, ep;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ex = (m_owner >= 0) ? int'(eng_x[8*m_owner +: 8]) : 0;
    ey = (m_owner >= 0) ? int'(eng_y[7*m_owner +: 7]) : 0;
    ec = (m_owner >= 0) ? int'(eng_colour[3*m_owner +: 3]) : 0;
    ep = (m_owner >= 0) ? int'(eng_plot[m_owner]) : 0;
    chk("gnt", gnt, eg);
    chk("eng_start", eng_start, eg);
    chk("busy", busy, (m_owner >= 0 || m_gap > 0) ? 1 : 0);
    chk("job_done", job_done, m_jd ? 1 : 0);
    chk("vga_x", vga_x, ex);
    chk("vga_y", vga_y, ey);
    chk("vga_colour", vga_colour, ec);
    chk("vga_plot", vga_plot, ep);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] rq;
    logic [2:0] dn;
    logic [2:0] pl;
    logic [2:0] e_gnt;
    logic       e_busy;
    logic       e_jd;
    logic       e_plot;
    logic [7:0] e_x;
  } vec_t;

  vec_t tbl[7];
  int   order[4];

  initial begin
    rst_n = 1'b0; req = '0; eng_done = '0; eng_plot = '0;
    eng_x      = {8'd7, 8'd159, 8'd10};
    eng_y      = {7'd3, 7'd119, 7'd2};
    eng_colour = {3'd6, 3'd5, 3'd1};

    //            rst   req     done    plot    gnt     busy  jd    plot  x
    tbl[0] = '{1'b1, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 3'b010, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, 8'd159};
    tbl[2] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0, 8'd159};
    tbl[3] = '{1'b1, 3'b000, 3'b010, 3'b010, 3'b010, 1'b1, 1'b0, 1'b1, 8'd159};
    tbl[4] = '{1'b1, 3'b000, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0};

`ifdef VGA_ARB_ROUND_ROBIN_EN
    order = '{0, 1, 2, 0};
`else
    order = '{0, 0, 0, 0};
`endif

    @(negedge clk);
    cyc(); cyc();

    // Single request, pixel pass-through, dropped request and completion.
    for (int i = 0; i < 7; i++) begin
      rst_n = tbl[i].rst; req = tbl[i].rq; eng_done = tbl[i].dn; eng_plot = tbl[i].pl;
      #1;
      chk("tbl_gnt", gnt, tbl[i].e_gnt);
      chk("tbl_busy", busy, tbl[i].e_busy);
      chk("tbl_job_done", job_done, tbl[i].e_jd);
      chk("tbl_vga_plot", vga_plot, tbl[i].e_plot);
      chk("tbl_vga_x", vga_x, tbl[i].e_x);
      if (tbl[i].e_plot) begin
        chk("tbl_vga_y", vga_y, 119);
        chk("tbl_vga_colour", vga_colour, 5);
      end
      $display("vec %0d req=%b done=%b gnt=%b busy=%b job_done=%b x=%0d",
               i, req, eng_done, gnt, busy, job_done, vga_x);
      cyc();
    end

    // Contention with all requests held; engine 0's job also checks isolation.
    rst_n = 1'b0; req = '0; eng_plot = '0; cyc();
    rst_n = 1'b1; req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      int t;
      t = 0;
      while (m_owner < 0 && t < 10) begin
        cyc();
        t++;
      end
      chk("grant_timeout", (m_owner >= 0) ? 1 : 0, 1);
      chk("rr_order", gnt, 1 << order[j]);
      $display("job %0d granted gnt=%b", j, gnt);
      if (j == 0) begin
        eng_plot = 3'b100; #1;
        chk("iso_plot", vga_plot, 0);
        chk("iso_x", vga_x, 10);
        cyc();
        eng_plot = 3'b101; #1;
        chk("iso_plot_own", vga_plot, 1);
        chk("iso_x_own", vga_x, 10);
        cyc();
        eng_plot = '0;
      end
      eng_done = 3'(1 << order[j]);
      cyc(); cyc();
      eng_done = '0;
    end

    // Reset in the middle of a job, then a lone request from engine 2.
    req = '0;
    while (m_owner >= 0 || m_gap > 0) cyc();
    cyc();
    req = 3'b010; eng_plot = 3'b010; cyc();
    chk("pre_rst_gnt", gnt, 3'b010);
    rst_n = 1'b0; req = '0; cyc();
    rst_n = 1'b1; #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    cyc();
    req = 3'b100; cyc();
    chk("post_rst_gnt", gnt, 3'b100);
    $display("post-reset grant gnt=%b", gnt);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      req        = 3'($urandom);
      eng_done   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      eng_plot   = 3'($urandom);
      eng_x      = 24'($urandom);
      eng_y      = 21'($urandom);
      eng_colour = 9'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
